// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and sizes for the cache refill memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int LINE_WORDS = 4;
    localparam int WORD_IDX_W = 2;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int LINE_W     = ADDR_W - WORD_IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Wait counter must hold MEM_WAIT; a zero wait still needs one bit.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Purpose  : One-hot winner selection between two refill requesters.
//            ARB_RR_EN selects round-robin ties; otherwise port 0 wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
`ifdef ARB_RR_EN
    input  logic       last,
`endif
    output logic [1:0] winner
);

    always_comb begin
        winner = 2'b00;
        if (req0 && req1) begin
`ifdef ARB_RR_EN
            // last=1 means port 1 was served most recently
            winner = last ? 2'b01 : 2'b10;
`else
            winner = 2'b01;
`endif
        end else if (req0) begin
            winner = 2'b01;
        end else if (req1) begin
            winner = 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_refill_arbiter
// Purpose  : Grants the memory read port to one of two cache refill ports and
//            runs a 4-word line burst with MEM_WAIT extra cycles per word.
//            Build macro ARB_RR_EN enables round-robin tie-break.
// Revision : 1.0 - initial release
// ============================================================================
module mem_refill_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_WAIT = 3
)
(
    input  logic                  clk_100,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [ADDR_W-1:0]     addr1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic [WORD_IDX_W-1:0] rword,
    output logic                  done0,
    output logic                  done1,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int                    c_cnt_w     = cnt_width(MEM_WAIT);
    localparam logic [c_cnt_w-1:0]    c_cnt_max   = c_cnt_w'(MEM_WAIT);
    localparam logic [WORD_IDX_W-1:0] c_last_word = WORD_IDX_W'(LINE_WORDS - 1);

    arb_state_t            r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [WORD_IDX_W-1:0] r_word;
    logic [LINE_W-1:0]     r_line;
    logic                  r_owner;

    logic [1:0]            w_winner;
    logic [LINE_W-1:0]     w_req_line;
    logic                  w_unused_addr_lsb;

    // Word offset bits of the miss address are irrelevant: bursts are line-aligned.
    assign w_unused_addr_lsb = ^{addr0[WORD_IDX_W-1:0], addr1[WORD_IDX_W-1:0]};
    assign w_req_line = w_winner[1] ? addr1[ADDR_W-1:WORD_IDX_W]
                                    : addr0[ADDR_W-1:WORD_IDX_W];

`ifdef ARB_RR_EN
    logic r_last;

    mem_arb_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (r_last),
        .winner (w_winner)
    );

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (r_state == DONE) begin
            r_last <= r_owner;
        end
    end
`else
    mem_arb_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .winner (w_winner)
    );
`endif

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_word   <= '0;
            r_line   <= '0;
            r_owner  <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rdata    <= '0;
            rvalid   <= 1'b0;
            rword    <= '0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    rvalid <= 1'b0;
                    done0  <= 1'b0;
                    done1  <= 1'b0;
                    if (|w_winner) begin
                        gnt0     <= w_winner[0];
                        gnt1     <= w_winner[1];
                        r_owner  <= w_winner[1];
                        r_line   <= w_req_line;
                        r_word   <= '0;
                        r_cnt    <= '0;
                        mem_addr <= {w_req_line, {WORD_IDX_W{1'b0}}};
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == c_cnt_max) begin
                        rdata  <= mem_rdata;
                        rvalid <= 1'b1;
                        rword  <= r_word;
                        r_cnt  <= '0;
                        if (r_word == c_last_word) begin
                            done0   <= ~r_owner;
                            done1   <= r_owner;
                            r_state <= DONE;
                        end else begin
                            r_word   <= r_word + 1'b1;
                            mem_addr <= {r_line, r_word + 2'd1};
                        end
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        rvalid <= 1'b0;
                    end
                end
                DONE: begin
                    // mem_addr deliberately keeps the last word address
                    rvalid  <= 1'b0;
                    done0   <= 1'b0;
                    done1   <= 1'b0;
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_refill_arbiter
// Purpose  : Self-checking bench; two arbiters (MEM_WAIT=3 and 0) share stimulus
//            and are scored against a burst-timing reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_refill_arbiter;

    localparam int W_A = 3;
    localparam int W_B = 0;

    typedef struct {
        logic        r0;
        logic        r1;
        logic [15:0] a0;
        logic [15:0] a1;
        logic        chg;
        logic [1:0]  exp_gnt;
        logic [15:0] exp_addr;
        logic [15:0] exp_last;
    } vec_t;

    logic        clk_100 = 1'b0;
    logic        rst, req0, req1;
    logic [15:0] addr0, addr1;

    logic        gnt0_a, gnt1_a, rvalid_a, done0_a, done1_a;
    logic [15:0] rdata_a, maddr_a, mrd_a;
    logic [1:0]  rword_a;
    logic        gnt0_b, gnt1_b, rvalid_b, done0_b, done1_b;
    logic [15:0] rdata_b, maddr_b, mrd_b;
    logic [1:0]  rword_b;

    logic [1:0]  obs_gnt [2];
    logic [1:0]  obs_done [2];
    logic        obs_rv [2];
    logic [1:0]  obs_rword [2];
    logic [15:0] obs_rdata [2];
    logic [15:0] obs_addr [2];

    int n_tests = 0;
    int n_fail  = 0;
    vec_t v [6];

    // Reference model state, one slot per DUT
    bit          m_act [2];
    int          m_t [2];
    int          m_win [2];
    int          m_last [2];
    logic [13:0] m_line [2];
    logic [15:0] m_hold [2];

    always #5 clk_100 = ~clk_100;

    // Memory returns address-derived data
    assign mrd_a = maddr_a ^ 16'h5A5A;
    assign mrd_b = maddr_b ^ 16'h5A5A;

    assign obs_gnt[0]   = {gnt1_a, gnt0_a};
    assign obs_gnt[1]   = {gnt1_b, gnt0_b};
    assign obs_done[0]  = {done1_a, done0_a};
    assign obs_done[1]  = {done1_b, done0_b};
    assign obs_rv[0]    = rvalid_a;
    assign obs_rv[1]    = rvalid_b;
    assign obs_rword[0] = rword_a;
    assign obs_rword[1] = rword_b;
    assign obs_rdata[0] = rdata_a;
    assign obs_rdata[1] = rdata_b;
    assign obs_addr[0]  = maddr_a;
    assign obs_addr[1]  = maddr_b;

    mem_refill_arbiter #(.MEM_WAIT(W_A)) u_dut_a (
        .clk_100 (clk_100), .rst (rst),
        .req0 (req0), .req1 (req1), .addr0 (addr0), .addr1 (addr1),
        .gnt0 (gnt0_a), .gnt1 (gnt1_a), .rdata (rdata_a), .rvalid (rvalid_a),
        .rword (rword_a), .done0 (done0_a), .done1 (done1_a),
        .mem_addr (maddr_a), .mem_rdata (mrd_a)
    );

    mem_refill_arbiter #(.MEM_WAIT(W_B)) u_dut_b (
        .clk_100 (clk_100), .rst (rst),
        .req0 (req0), .req1 (req1), .addr0 (addr0), .addr1 (addr1),
        .gnt0 (gnt0_b), .gnt1 (gnt1_b), .rdata (rdata_b), .rvalid (rvalid_b),
        .rword (rword_b), .done0 (done0_b), .done1 (done1_b),
        .mem_addr (maddr_b), .mem_rdata (mrd_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int per(input int i);
        return (i == 0) ? W_A + 1 : W_B + 1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i]  = 1'b0;
            m_t[i]    = 0;
            m_win[i]  = 0;
            m_last[i] = 1;
            m_line[i] = '0;
            m_hold[i] = '0;
        end
    endfunction

    function automatic int pick(input int i);
        if (req0 && req1) begin
`ifdef ARB_RR_EN
            return (m_last[i] == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        return req0 ? 0 : 1;
    endfunction

    // Burst of 4 words, one every P cycles after the grant edge; gnt held
    // through t=4P, next grant possible two edges later.
    task automatic model_check();
        for (int i = 0; i < 2; i++) begin
            int          p;
            int          k;
            logic [1:0]  e_gnt;
            logic [1:0]  e_done;
            logic        e_rv;
            logic [15:0] e_addr;
            logic [1:0]  e_word;
            p      = per(i);
            k      = (m_t[i] / p > 3) ? 3 : m_t[i] / p;
            e_gnt  = m_act[i] ? ((m_win[i] == 1) ? 2'b10 : 2'b01) : 2'b00;
            e_rv   = m_act[i] && (m_t[i] > 0) && (m_t[i] % p == 0);
            e_done = (m_act[i] && m_t[i] == 4 * p) ? e_gnt : 2'b00;
            e_addr = m_act[i] ? {m_line[i], 2'(k)} : m_hold[i];
            chk($sformatf("mdl%0d_gnt", i), 32'(obs_gnt[i]), 32'(e_gnt));
            chk($sformatf("mdl%0d_rvalid", i), 32'(obs_rv[i]), 32'(e_rv));
            chk($sformatf("mdl%0d_done", i), 32'(obs_done[i]), 32'(e_done));
            chk($sformatf("mdl%0d_mem_addr", i), 32'(obs_addr[i]), 32'(e_addr));
            if (e_rv) begin
                e_word = 2'(m_t[i] / p - 1);
                chk($sformatf("mdl%0d_rword", i), 32'(obs_rword[i]), 32'(e_word));
                chk($sformatf("mdl%0d_rdata", i), 32'(obs_rdata[i]),
                    32'({m_line[i], e_word} ^ 16'h5A5A));
            end
        end
    endtask

    always @(posedge clk_100) begin
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_act[i]) begin
                    m_t[i]++;
                    if (m_t[i] == 4 * per(i) + 1) begin
                        m_act[i]  = 1'b0;
                        m_last[i] = m_win[i];
                        m_hold[i] = {m_line[i], 2'b11};
                    end
                end else if (req0 || req1) begin
                    m_win[i]  = pick(i);
                    m_line[i] = (m_win[i] == 1) ? addr1[15:2] : addr0[15:2];
                    m_act[i]  = 1'b1;
                    m_t[i]    = 0;
                end
            end
        end
        #1;
        model_check();
    end

    // Called at a negedge: reset must clear outputs without waiting for a clock.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_ctl_a", {gnt1_a, gnt0_a, rvalid_a, done1_a, done0_a, rword_a}, 0);
        chk("async_rst_data_a", {rdata_a, maddr_a}, 0);
        chk("async_rst_ctl_b", {gnt1_b, gnt0_b, rvalid_b, done1_b, done0_b, rword_b}, 0);
        chk("async_rst_data_b", {rdata_b, maddr_b}, 0);
        @(negedge clk_100);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          n, nrv, nd, frv, dc, gfall, bdc;
        logic [1:0]  g0, fword, bdw;
        logic [15:0] ad0, lastd;
        logic [3:0]  bmask;
        logic [7:0]  bw;
        bit          seen1;

        v[0] = '{1'b0, 1'b1, 16'h0000, 16'h0080, 1'b0, 2'b10, 16'h0080, 16'h5AD9};
        v[1] = '{1'b1, 1'b0, 16'h12A7, 16'h0000, 1'b0, 2'b01, 16'h12A4, 16'h48FD};
        v[2] = '{1'b0, 1'b1, 16'h0000, 16'h0003, 1'b0, 2'b10, 16'h0000, 16'h5A59};
        v[3] = '{1'b1, 1'b1, 16'h1000, 16'h2000, 1'b0, 2'b01, 16'h1000, 16'h4A59};
`ifdef ARB_RR_EN
        v[4] = '{1'b1, 1'b1, 16'h1000, 16'h2000, 1'b0, 2'b10, 16'h2000, 16'h7A59};
`else
        v[4] = '{1'b1, 1'b1, 16'h1000, 16'h2000, 1'b0, 2'b01, 16'h1000, 16'h4A59};
`endif
        v[5] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 2'b01, 16'h1234, 16'h486D};

        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk_100);
        #2;
        chk("reset_ctl_a", {gnt1_a, gnt0_a, rvalid_a, done1_a, done0_a, rword_a}, 0);
        chk("reset_data_a", {rdata_a, maddr_a}, 0);
        chk("reset_ctl_b", {gnt1_b, gnt0_b, rvalid_b, done1_b, done0_b, rword_b}, 0);

        // Tie straight out of reset: port 0 first, port 1 at E18
        @(negedge clk_100);
        req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0100; addr1 = 16'h0200; rst = 1'b0;
        seen1 = 1'b0;
        for (int c = 0; c < 40 && !seen1; c++) begin
            @(posedge clk_100); #1;
            if (c == 0)  chk("tie_first_gnt", {gnt1_a, gnt0_a}, 2'b01);
            if (c == 17) chk("tie_gap_gnt", {gnt1_a, gnt0_a}, 2'b00);
            if (c == 18) chk("tie_second_gnt", {gnt1_a, gnt0_a}, 2'b10);
            if (done0_a) req0 = 1'b0;
            if (done1_a) begin
                req1  = 1'b0;
                seen1 = 1'b1;
            end
        end
        chk("tie_done1_seen", seen1, 1);
        req0 = 1'b0; req1 = 1'b0;
        repeat (8) @(negedge clk_100);

        // Reset after the second word of a burst
        req0 = 1'b1; addr0 = 16'h0040;
        n = 0;
        for (int c = 0; c < 40 && n < 2; c++) begin
            @(posedge clk_100); #1;
            if (rvalid_a) n++;
        end
        chk("rstmid_two_words", n, 2);
        @(negedge clk_100);
        req0 = 1'b0;
        do_reset();

        for (int e = 0; e < 6; e++) begin
            @(negedge clk_100);
            req0 = v[e].r0; req1 = v[e].r1; addr0 = v[e].a0; addr1 = v[e].a1;
            nrv = 0; nd = 0; frv = -1; dc = -1; gfall = -1; bdc = -1;
            g0 = '0; ad0 = '0; lastd = '0; fword = '1; bmask = '0; bw = '0; bdw = '0;
            for (int c = 0; c < 24; c++) begin
                @(posedge clk_100); #1;
                if (c == 0) begin
                    g0  = {gnt1_a, gnt0_a};
                    ad0 = maddr_a;
                end
                if (rvalid_a) begin
                    if (nrv == 0) begin
                        frv   = c;
                        fword = rword_a;
                    end
                    nrv++;
                    lastd = rdata_a;
                end
                if (done0_a || done1_a) begin
                    nd++;
                    dc   = c;
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
                if (gfall < 0 && c > 0 && !gnt0_a && !gnt1_a) gfall = c;
                if (v[e].chg && c == 6) begin
                    req0  = 1'b0;
                    addr0 = 16'hFFFF;
                end
                if (c >= 1 && c <= 4) begin
                    bmask[c-1]        = rvalid_b;
                    bw[2*(c-1) +: 2]  = rword_b;
                end
                if (bdc < 0 && (done0_b || done1_b)) begin
                    bdc = c;
                    bdw = rword_b;
                end
            end
            chk($sformatf("v%0d_gnt", e), g0, v[e].exp_gnt);
            chk($sformatf("v%0d_first_addr", e), ad0, v[e].exp_addr);
            chk($sformatf("v%0d_num_rvalid", e), nrv, 4);
            chk($sformatf("v%0d_num_done", e), nd, 1);
            chk($sformatf("v%0d_first_rv_cycle", e), frv, 4);
            chk($sformatf("v%0d_first_rword", e), fword, 0);
            chk($sformatf("v%0d_done_cycle", e), dc, 16);
            chk($sformatf("v%0d_last_rdata", e), lastd, v[e].exp_last);
            chk($sformatf("v%0d_gnt_fall", e), gfall, 17);
            chk($sformatf("v%0d_w0_rv_mask", e), bmask, 4'b1111);
            chk($sformatf("v%0d_w0_rwords", e), bw, 8'hE4);
            chk($sformatf("v%0d_w0_done_cycle", e), bdc, 4);
            chk($sformatf("v%0d_w0_done_rword", e), bdw, 3);
            req0 = 1'b0; req1 = 1'b0;
            repeat (8) @(negedge clk_100);
        end

        // Random traffic, address churn and occasional resets
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk_100);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) req0 = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) req1 = 1'($urandom_range(0, 1));
                addr0 = 16'($urandom);
                addr1 = 16'($urandom);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (40) @(negedge clk_100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Shares the single 16-bit word-addressed main-memory read port between two cache refill requesters (port 0: instruction cache, port 1: data cache). It grants one requester at a time and runs a fixed 4-word line burst against memory, with a programmable wait per word. It returns each word with its index, and signals burst completion. It sits between the cache miss logic and the memory, and replaces per-cache memory sequencing.

## Interface
- MEM_WAIT, 3: extra cycles `mem_addr` is held before `mem_rdata` is sampled; legal range 0..15
- clk_100  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  refill request; held high until that port's `done` is seen
- addr0, addr1  in  16  miss address; bits [1:0] ignored, line = bits [15:2]
- gnt0, gnt1  out  1  port owns the memory; high for the whole burst, one-hot or zero
- rdata  out  16  returned word
- rvalid  out  1  one-cycle pulse per word, to the granted port
- rword  out  2  word index of `rdata` (0..3)
- done0, done1  out  1  one-cycle pulse coinciding with the port's 4th `rvalid`
- mem_addr  out  16  memory read address {line, word}
- mem_rdata  in  16  memory read data

## Operation
- State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE, at an edge with any req high:
  - pick the winner
  - gntN<=1, latch line<=addrN[15:2], word<=0, cnt<=0
  - mem_addr<={addrN[15:2],2'b00}
  - go to BUSY
- BUSY, when cnt!=MEM_WAIT: cnt<=cnt+1.
- BUSY, when cnt==MEM_WAIT:
  - rdata<=mem_rdata, rvalid<=1, rword<=word, cnt<=0
  - if word==3: doneN<=1, go to DONE
  - else: word<=word+1, mem_addr<={line,word+1}
- BUSY, any other cycle: rvalid<=0.
- DONE: rvalid<=0, doneN<=0, gntN<=0, last<=winner, go to IDLE. `mem_addr` holds its last value.
- Tie (both req in IDLE): grant the port that is not `last`. `last` resets to 1, so port 0 wins the first tie.
- Single req: granted regardless of `last`.
- req deasserted mid-burst: ignored; there is no abort and the burst completes.
- addrN changing mid-burst: ignored, because the line is latched.
- Reset asserted at any time (including mid-burst):
  - all outputs 0 immediately, state IDLE, cnt/word 0, last=1
  - the partial burst is discarded; the requester must re-request
- cnt width = max(1, clog2(MEM_WAIT+1)). word is 2 bits and never wraps past 3 inside a burst.
- Output reset values: gnt0=gnt1=0, rdata=0, rvalid=0, rword=0, done0=done1=0, mem_addr=0.

## Timing
- Edge E0: IDLE samples req; gnt and mem_addr are valid after E0.
- Word k sampled at edge E0+(k+1)*(MEM_WAIT+1); rvalid is high in the following cycle.
- MEM_WAIT=3: samples at E4, E8, E12, E16; done is high after E16; gnt falls at E17; earliest next grant is at E18.
- MEM_WAIT=0: one word per cycle; done is high after E4.
- A requester that registers `done` drops req at E17, so IDLE does not re-grant it.
- No combinational path from req/addr to any output.

## Configuration
- ARB_RR_EN defined: round-robin tie-break using `last`, as above.
- ARB_RR_EN undefined:
  - fixed priority, port 0 always wins ties
  - the `last` register is not built
  - port 1 can starve under continuous port-0 requests

## Structure
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY, DONE}
  - LINE_WORDS=4, WORD_IDX_W=2, ADDR_W=16, DATA_W=16
- Sub-module mem_arb_pick: takes req0, req1, last and returns a one-hot winner. It holds the ARB_RR_EN selection so the FSM is policy-agnostic.
- The top level holds the FSM, cnt/word counters, latched line and output registers.

## Test plan
- Single refill: MEM_WAIT=3, req0 with addr0=16'h12A7, memory returns addr^16'h5A5A -> mem_addr 12A4..12A7; rvalid after E4/E8/E12/E16 with rword 0..3 and rdata = addr^5A5A; done0 with the 4th word; gnt0 falls at E17.
- Tie: req0 and req1 both high from reset -> port 0 served first, then port 1 granted at E18. With a second simultaneous tie after that, port 0 is served again (RR); without ARB_RR_EN, port 0 always wins.
- Reset mid-burst: assert rst after the 2nd rvalid -> all outputs 0 immediately; after release, a new req1 gets a clean burst starting at word 0.
- Mid-burst changes: req0 drops and addr0 changes to 16'hFFFF at E6 -> burst still completes on the original line; exactly 4 rvalid and 1 done0.
- MEM_WAIT=0: req1 addr 16'h0003 -> mem_addr 0000..0003; rvalid on 4 consecutive cycles; done1 with rword=3.
